hex_operand_loader: RTL

Upstream operand stage for the 8-bit hex adder: assembles two 8-bit operands A and B from a stream of single-digit hex key strobes (high nibble first, A before B) and presents them to the adder's A/B inputs with a valid/consume handshake. It replaces the static DIP operand switches with a sequenced keypad entry path. Both operands update atomically, so the adder never sees a half-entered pair.

---
 rtl/hex_loader_pkg.sv | 27 ++
 rtl/hex_byte_assembler.sv | 27 ++
 rtl/hex_operand_loader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/hex_loader_pkg.sv
// Shared types and widths for the hex operand loader.
// Holds the entry FSM state enum and the nibble-to-digit index helper.
package hex_loader_pkg;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;

    typedef enum logic [2:0] {
        A_HI,
        A_LO,
        B_HI,
        B_LO,
        FULL
    } state_t;

    // FULL reports 0 so the keypad display points back at A_HI.
    function automatic logic [1:0] digit_index(input state_t s);
        case (s)
            A_HI:    digit_index = 2'd0;
            A_LO:    digit_index = 2'd1;
            B_HI:    digit_index = 2'd2;
            B_LO:    digit_index = 2'd3;
            default: digit_index = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/hex_byte_assembler.sv
// Shadow byte for one operand: loads the high nibble (zeroing the low one),
// loads the low nibble, or clears.
module hex_byte_assembler
    import hex_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                load_hi,
    input  logic                load_lo,
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [BYTE_W-1:0]   byte_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q <= '0;
        end else if (clear) begin
            byte_q <= '0;
        end else if (load_hi) begin
            byte_q <= {nibble, {NIBBLE_W{1'b0}}};
        end else if (load_lo) begin
            byte_q[NIBBLE_W-1:0] <= nibble;
        end
    end

endmodule

// File: rtl/hex_operand_loader.sv
// Keypad operand entry for the 8-bit hex adder: four digits build A then B,
// and the pair is published atomically. Optional echo: HEX_OPERAND_LOADER_ECHO_EN.
module hex_operand_loader
    import hex_loader_pkg::*;
#(
    parameter int DROP_CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_valid,
    input  logic [NIBBLE_W-1:0]   key_code,
    input  logic                  key_clear,
    input  logic                  consume,
    output logic [BYTE_W-1:0]     a,
    output logic [BYTE_W-1:0]     b,
    output logic                  operands_valid,
    output logic [1:0]            digit_idx,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic [BYTE_W-1:0]     echo
);

    state_t              state;
    state_t              next_state;
    logic                accept;
    logic                shadow_clear;
    logic                load_a_hi;
    logic                load_a_lo;
    logic                load_b_hi;
    logic                commit;
    logic                drop_inc;
    logic [BYTE_W-1:0]   shadow_a;
    logic [BYTE_W-1:0]   shadow_b;
    logic [BYTE_W-1:0]   b_commit;

    hex_byte_assembler u_shadow_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (shadow_clear),
        .load_hi (load_a_hi),
        .load_lo (load_a_lo),
        .nibble  (key_code),
        .byte_q  (shadow_a)
    );

    hex_byte_assembler u_shadow_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (shadow_clear),
        .load_hi (load_b_hi),
        .load_lo (1'b0),
        .nibble  (key_code),
        .byte_q  (shadow_b)
    );

    // The low nibble of shadow_b is always zero in B_LO, so OR-ing merges the last digit.
    assign b_commit = {shadow_b[BYTE_W-1:NIBBLE_W], shadow_b[NIBBLE_W-1:0] | key_code};

    always_comb begin
        next_state   = state;
        accept       = key_valid && !key_clear && !consume;
        shadow_clear = key_clear || (consume && state == FULL);
        load_a_hi    = 1'b0;
        load_a_lo    = 1'b0;
        load_b_hi    = 1'b0;
        commit       = 1'b0;
        drop_inc     = 1'b0;
        if (key_clear) begin
            next_state = A_HI;
        end else if (state == FULL) begin
            if (consume) begin
                next_state = A_HI;
            end else if (key_valid) begin
                drop_inc = 1'b1;
            end
        end else if (accept) begin
            case (state)
                A_HI: begin
                    load_a_hi  = 1'b1;
                    next_state = A_LO;
                end
                A_LO: begin
                    load_a_lo  = 1'b1;
                    next_state = B_HI;
                end
                B_HI: begin
                    load_b_hi  = 1'b1;
                    next_state = B_LO;
                end
                B_LO: begin
                    commit     = 1'b1;
                    next_state = FULL;
                end
                default: next_state = A_HI;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= A_HI;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a              <= '0;
            b              <= '0;
            operands_valid <= 1'b0;
        end else if (commit) begin
            a              <= shadow_a;
            b              <= b_commit;
            operands_valid <= 1'b1;
        end else if (shadow_clear) begin
            operands_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_inc && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

    assign digit_idx = digit_index(state);

`ifdef HEX_OPERAND_LOADER_ECHO_EN
    // Echo mirrors the byte just modified; after B_LO that is the loaded b.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo <= '0;
        end else if (shadow_clear) begin
            echo <= '0;
        end else if (accept) begin
            case (state)
                A_HI:    echo <= {key_code, {NIBBLE_W{1'b0}}};
                A_LO:    echo <= {shadow_a[BYTE_W-1:NIBBLE_W], key_code};
                B_HI:    echo <= {key_code, {NIBBLE_W{1'b0}}};
                B_LO:    echo <= b_commit;
                default: echo <= echo;
            endcase
        end
    end
`else
    assign echo = '0;
`endif

endmodule
